// File: rtl/mips_cpu_pc_seq.sv
// rtl/mips_cpu_pc_seq.sv - MIPS program-counter sequencer with optional branch delay slot
module mips_cpu_pc_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter int          DELAY_SLOTS  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] pc,
    output logic        active,
    output logic        fault,
    output logic        in_delay_slot,
    output logic        link_we,
    output logic [4:0]  link_reg,
    output logic [31:0] link_data
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RI_BLTZ    = 5'b00000;
    localparam logic [4:0] RI_BGEZ    = 5'b00001;
    localparam logic [4:0] RI_BLTZAL  = 5'b10000;
    localparam logic [4:0] RI_BGEZAL  = 5'b10001;
    localparam logic [31:0] LINK_OFS  = (DELAY_SLOTS != 0) ? 32'd8 : 32'd4;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_sel;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        rs_neg;
    logic        rs_zero;
    logic        taken;
    logic        is_link;
    logic        is_reg;
    logic        is_jalr;
    logic [31:0] target;
    logic        target_bad;
    logic        issue;
    logic        pending;
    logic [31:0] dest;
    logic        dest_bad;
    logic        unused_shamt;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign rt_sel    = instr[20:16];
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign rs_neg    = rs_data[31];
    assign rs_zero   = (rs_data == 32'd0);
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        taken   = 1'b0;
        is_link = 1'b0;
        is_reg  = 1'b0;
        is_jalr = 1'b0;
        target  = br_target;
        case (opcode)
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    taken   = 1'b1;
                    is_reg  = 1'b1;
                    target  = rs_data;
                    is_jalr = (funct == FN_JALR);
                    is_link = (funct == FN_JALR);
                end
            end
            OP_J: begin
                taken  = 1'b1;
                target = j_target;
            end
            OP_JAL: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = j_target;
            end
            OP_BEQ:  taken = (rs_data == rt_data);
            OP_BNE:  taken = (rs_data != rt_data);
            OP_BLEZ: taken = rs_neg | rs_zero;
            OP_BGTZ: taken = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                case (rt_sel)
                    RI_BLTZ:   taken = rs_neg;
                    RI_BGEZ:   taken = !rs_neg;
                    RI_BLTZAL: begin
                        taken   = rs_neg;
                        is_link = 1'b1;
                    end
                    RI_BGEZAL: begin
                        taken   = !rs_neg;
                        is_link = 1'b1;
                    end
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

    // Only register-indirect targets can be misaligned; immediates are always word-aligned.
    assign target_bad = is_reg && (target[1:0] != 2'b00);
    assign issue      = active && !stall && !in_delay_slot;
    assign link_we    = issue && is_link && !reset;
    assign link_reg   = is_jalr ? instr[15:11] : 5'd31;
    assign link_data  = pc + LINK_OFS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_VECTOR;
            active        <= 1'b1;
            fault         <= 1'b0;
            in_delay_slot <= 1'b0;
            pending       <= 1'b0;
            dest          <= 32'd0;
            dest_bad      <= 1'b0;
        end else if (active && !stall) begin
            if (pending) begin
                // Delay slot retires: the earlier transfer commits now, whatever this instr is.
                pending       <= 1'b0;
                in_delay_slot <= 1'b0;
                if (dest_bad) begin
                    fault  <= 1'b1;
                    active <= 1'b0;
                end else begin
                    pc <= dest;
                    if (dest == HALT_ADDR) active <= 1'b0;
                end
            end else if (taken && DELAY_SLOTS != 0) begin
                pc            <= pc_plus4;
                dest          <= target;
                dest_bad      <= target_bad;
                pending       <= 1'b1;
                in_delay_slot <= 1'b1;
                if (pc_plus4 == HALT_ADDR) active <= 1'b0;
            end else if (taken) begin
                if (target_bad) begin
                    fault  <= 1'b1;
                    active <= 1'b0;
                end else begin
                    pc <= target;
                    if (target == HALT_ADDR) active <= 1'b0;
                end
            end else begin
                pc <= pc_plus4;
                if (pc_plus4 == HALT_ADDR) active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// tb/tb_mips_cpu_pc_seq.sv - bench for mips_cpu_pc_seq, both delay-slot variants side by side
module tb_mips_cpu_pc_seq;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic [31:0] pc_o [2];
    logic        active_o [2];
    logic        fault_o [2];
    logic        ids_o [2];
    logic        lwe_o [2];
    logic [4:0]  lreg_o [2];
    logic [31:0] ldata_o [2];

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = no delay slot, index 1 = one delay slot.
    logic [31:0] m_pc [2];
    logic [31:0] m_dest [2];
    bit          m_act [2];
    bit          m_flt [2];
    bit          m_ids [2];
    bit          m_bad [2];

    mips_cpu_pc_seq #(.DELAY_SLOTS(0)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .pc(pc_o[0]), .active(active_o[0]),
        .fault(fault_o[0]), .in_delay_slot(ids_o[0]), .link_we(lwe_o[0]),
        .link_reg(lreg_o[0]), .link_data(ldata_o[0])
    );

    mips_cpu_pc_seq dut1 (
        .clk(clk), .reset(reset), .stall(stall), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .pc(pc_o[1]), .active(active_o[1]),
        .fault(fault_o[1]), .in_delay_slot(ids_o[1]), .link_we(lwe_o[1]),
        .link_reg(lreg_o[1]), .link_data(ldata_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] pcv,
                                       output bit taken, output logic [31:0] tgt,
                                       output bit link, output bit regt);
        logic [31:0] seq;
        logic signed [15:0] imm;
        int off;
        int srs;
        seq   = pcv + 32'd4;
        imm   = ins[15:0];
        off   = int'(imm) * 4;
        srs   = int'(rs);
        taken = 1'b0;
        link  = 1'b0;
        regt  = 1'b0;
        tgt   = seq + 32'(off);
        case (ins[31:26])
            6'd0: if (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) begin
                taken = 1'b1;
                regt  = 1'b1;
                tgt   = rs;
                link  = (ins[5:0] == 6'd9);
            end
            6'd2, 6'd3: begin
                taken = 1'b1;
                tgt   = {seq[31:28], ins[25:0], 2'b00};
                link  = (ins[31:26] == 6'd3);
            end
            6'd4: taken = (rs == rt);
            6'd5: taken = (rs != rt);
            6'd6: taken = (srs <= 0);
            6'd7: taken = (srs > 0);
            6'd1: begin
                if (ins[20:16] == 5'd0 || ins[20:16] == 5'd16) taken = (srs < 0);
                if (ins[20:16] == 5'd1 || ins[20:16] == 5'd17) taken = (srs >= 0);
                link = (ins[20:16] == 5'd16 || ins[20:16] == 5'd17);
            end
            default: taken = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = 32'hBFC00000;
            m_dest[k] = 32'd0;
            m_act[k]  = 1'b1;
            m_flt[k]  = 1'b0;
            m_ids[k]  = 1'b0;
            m_bad[k]  = 1'b0;
        end
    endtask

    task automatic model_next(input int k, input bit st, input logic [31:0] ins,
                              input logic [31:0] rs, input logic [31:0] rt);
        bit taken, link, regt;
        logic [31:0] tgt;
        if (st || !m_act[k]) return;
        if (m_ids[k]) begin
            m_ids[k] = 1'b0;
            if (m_bad[k]) begin
                m_flt[k] = 1'b1;
                m_act[k] = 1'b0;
            end else m_pc[k] = m_dest[k];
        end else begin
            ref_decode(ins, rs, rt, m_pc[k], taken, tgt, link, regt);
            if (!taken) m_pc[k] = m_pc[k] + 32'd4;
            else if (k == 1) begin
                m_pc[k]   = m_pc[k] + 32'd4;
                m_dest[k] = tgt;
                m_bad[k]  = regt && (tgt[1:0] != 2'b00);
                m_ids[k]  = 1'b1;
            end else if (regt && tgt[1:0] != 2'b00) begin
                m_flt[k] = 1'b1;
                m_act[k] = 1'b0;
            end else m_pc[k] = tgt;
        end
        if (!m_flt[k] && m_pc[k] == 32'd0) m_act[k] = 1'b0;
    endtask

    task automatic step(input bit st, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt);
        bit taken, link, regt;
        logic [31:0] tgt;
        stall = st; instr = ins; rs_data = rs; rt_data = rt;
        #2;
        for (int k = 0; k < 2; k++) begin
            ref_decode(ins, rs, rt, m_pc[k], taken, tgt, link, regt);
            chk($sformatf("pc%0d", k), pc_o[k], m_pc[k]);
            chk($sformatf("active%0d", k), 32'(active_o[k]), 32'(m_act[k]));
            chk($sformatf("fault%0d", k), 32'(fault_o[k]), 32'(m_flt[k]));
            chk($sformatf("in_ds%0d", k), 32'(ids_o[k]), 32'(m_ids[k]));
            chk($sformatf("link_we%0d", k), 32'(lwe_o[k]),
                32'(link && m_act[k] && !st && !m_ids[k]));
            chk($sformatf("link_reg%0d", k), 32'(lreg_o[k]),
                (ins[31:26] == 6'd0 && ins[5:0] == 6'd9) ? 32'(ins[15:11]) : 32'd31);
            chk($sformatf("link_data%0d", k), ldata_o[k], m_pc[k] + ((k == 1) ? 32'd8 : 32'd4));
        end
        for (int k = 0; k < 2; k++) model_next(k, st, ins, rs, rt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0; instr = 32'h0C000100; rs_data = 32'd0; rt_data = 32'd0;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_pc%0d", k), pc_o[k], 32'hBFC00000);
            chk($sformatf("rst_active%0d", k), 32'(active_o[k]), 32'd1);
            chk($sformatf("rst_fault%0d", k), 32'(fault_o[k]), 32'd0);
            chk($sformatf("rst_in_ds%0d", k), 32'(ids_o[k]), 32'd0);
            chk($sformatf("rst_link_we%0d", k), 32'(lwe_o[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    localparam logic [31:0] NOP = 32'h20000000;

    initial begin
        logic [31:0] ins, rs, rt, r;
        bit st;
        reset = 1'b0; stall = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        model_reset();
        do_reset();

        // JAL from BFC00010
        for (int i = 0; i < 4; i++) step(0, NOP, 32'd0, 32'd0);
        chk("pre_jal_pc", pc_o[1], 32'hBFC00010);
        instr = 32'h0C000100;
        #1;
        chk("jal_link_we", 32'(lwe_o[1]), 32'd1);
        chk("jal_link_reg", 32'(lreg_o[1]), 32'd31);
        chk("jal_link_data", ldata_o[1], 32'hBFC00018);
        chk("jal_link_data_ds0", ldata_o[0], 32'hBFC00014);
        step(0, 32'h0C000100, 32'd0, 32'd0);
        chk("jal_slot_pc", pc_o[1], 32'hBFC00014);
        chk("jal_slot_flag", 32'(ids_o[1]), 32'd1);
        chk("jal_ds0_pc", pc_o[0], 32'hB0000400);
        step(0, NOP, 32'd0, 32'd0);
        chk("jal_target_pc", pc_o[1], 32'hB0000400);

        // Zero-delay-slot branches
        do_reset();
        for (int i = 0; i < 2; i++) step(0, NOP, 32'd0, 32'd0);
        step(0, 32'h0400FFFF, 32'hFFFFFFFF, 32'd0);
        chk("bltz_ds0_pc", pc_o[0], 32'hBFC00008);
        chk("bltz_ds0_in_ds", 32'(ids_o[0]), 32'd0);
        step(0, 32'h1C000003, 32'h80000000, 32'd0);
        chk("bgtz_ds0_pc", pc_o[0], 32'hBFC0000C);

        // JR to the halt address
        do_reset();
        for (int i = 0; i < 8; i++) step(0, NOP, 32'd0, 32'd0);
        step(0, 32'h03E00008, 32'd0, 32'd0);
        chk("jr_slot_pc", pc_o[1], 32'hBFC00024);
        chk("jr_slot_active", 32'(active_o[1]), 32'd1);
        step(0, NOP, 32'd0, 32'd0);
        chk("halt_pc", pc_o[1], 32'h00000000);
        chk("halt_active", 32'(active_o[1]), 32'd0);
        for (int i = 0; i < 3; i++) step(0, NOP, 32'd0, 32'd0);
        chk("halt_hold_pc", pc_o[1], 32'h00000000);

        // Misaligned JALR
        do_reset();
        instr = 32'h00202809; rs_data = 32'hBFC00102;
        #1;
        chk("jalr_link_we", 32'(lwe_o[1]), 32'd1);
        chk("jalr_link_reg", 32'(lreg_o[1]), 32'd5);
        step(0, 32'h00202809, 32'hBFC00102, 32'd0);
        chk("jalr_ds0_fault", 32'(fault_o[0]), 32'd1);
        chk("jalr_ds0_pc", pc_o[0], 32'hBFC00000);
        step(0, NOP, 32'd0, 32'd0);
        chk("jalr_fault", 32'(fault_o[1]), 32'd1);
        chk("jalr_active", 32'(active_o[1]), 32'd0);
        chk("jalr_pc", pc_o[1], 32'hBFC00004);

        // Stall inside a delay slot, then reset discards the pending target
        do_reset();
        step(0, 32'h10000004, 32'd5, 32'd5);
        for (int i = 0; i < 3; i++) step(1, NOP, 32'd0, 32'd0);
        chk("stall_pc", pc_o[1], 32'hBFC00004);
        chk("stall_in_ds", 32'(ids_o[1]), 32'd1);
        do_reset();
        step(0, NOP, 32'd0, 32'd0);
        chk("post_reset_pc", pc_o[1], 32'hBFC00004);

        // Randomised instruction stream
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (!m_act[0] || !m_act[1] || $urandom_range(0, 49) == 0) do_reset();
            r = $urandom;
            case ($urandom_range(0, 10))
                0:  ins = {6'b001000, r[25:0]};
                1:  ins = {6'b000010, r[25:0]};
                2:  ins = {6'b000011, r[25:0]};
                3:  ins = {6'b000000, r[25:6], 6'b001000};
                4:  ins = {6'b000000, r[25:6], 6'b001001};
                5:  ins = {6'b000100, r[25:0]};
                6:  ins = {6'b000101, r[25:0]};
                7:  ins = {6'b000110, r[25:0]};
                8:  ins = {6'b000111, r[25:0]};
                9:  ins = {6'b000001, r[25:21], r[20] ? 5'b10000 : 5'b00000, r[15:0]} | {15'd0, r[16], 16'd0};
                default: ins = {6'b000001, r[25:0]};
            endcase
            rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            st = ($urandom_range(0, 7) == 0);
            step(st, ins, rs, rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
